// File: rtl/pipe_stage_reg_pkg.sv
// Shared types and helpers for the inter-stage pipeline register.
// Stall-bus polarity, lane limit and the per-cycle control decode live here.
package pipe_stage_reg_pkg;

    localparam logic STOP = 1'b1;
    localparam logic NO_STOP = 1'b0;
    localparam int LANES_MAX = 4;
    localparam int PERF_W = 32;
    localparam logic [PERF_W-1:0] PERF_MAX = '1;

    typedef enum logic [1:0] {
        CTL_HOLD,
        CTL_LOAD,
        CTL_CLEAR
    } stage_ctl_e;

    // Flush outranks every stall combination; a bubble clears like flush.
    function automatic stage_ctl_e decode_ctl(
        input logic flush,
        input logic up,
        input logic dn
    );
        stage_ctl_e ctl;
        ctl = CTL_HOLD;
        priority case (1'b1)
            flush: ctl = CTL_CLEAR;
            (up == STOP && dn == NO_STOP): ctl = CTL_CLEAR;
            (up == NO_STOP): ctl = CTL_LOAD;
            default: ctl = CTL_HOLD;
        endcase
        return ctl;
    endfunction

    function automatic logic [PERF_W-1:0] sat_inc(
        input logic [PERF_W-1:0] v
    );
        return (v == PERF_MAX) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/pipe_lane_reg.sv
// One issue lane of the stage register: {valid, pc, data} with clear/load/hold.
// A lane loaded as not-valid carries zero PC and payload.
module pipe_lane_reg #(
    parameter int PC_W = 32,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              clr,
    input  logic              ld,
    input  logic              nxt_valid,
    input  logic [PC_W-1:0]   nxt_pc,
    input  logic [DATA_W-1:0] nxt_data,
    output logic              valid,
    output logic [PC_W-1:0]   pc,
    output logic [DATA_W-1:0] data
);

    always_ff @(posedge clk) begin
        if (!resetn || clr) begin
            valid <= 1'b0;
            pc <= '0;
            data <= '0;
        end else if (ld) begin
            valid <= nxt_valid;
            pc <= nxt_valid ? nxt_pc : '0;
            data <= nxt_valid ? nxt_data : '0;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Multi-lane pipeline register driven by the global stall bus, with flush and per-lane kill.
// Optional perf counters are built when PIPE_STAGE_PERF_EN is defined.
module pipe_stage_reg
    import pipe_stage_reg_pkg::*;
#(
    parameter int LANES = 2,
    parameter int PC_W = 32,
    parameter int DATA_W = 64,
    parameter int STALL_W = 7,
    parameter int STAGE_IDX = 5,
    localparam int CNT_W = $clog2(LANES + 1)
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    flush,
    input  logic [STALL_W-1:0]      stall,
    input  logic [LANES-1:0]        in_valid,
    input  logic [LANES-1:0]        in_kill,
    input  logic [LANES*PC_W-1:0]   in_pc,
    input  logic [LANES*DATA_W-1:0] in_data,
    output logic [LANES-1:0]        out_valid,
    output logic [LANES*PC_W-1:0]   out_pc,
    output logic [LANES*DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]        out_count,
    input  logic                    perf_clr,
    output logic [PERF_W-1:0]       perf_stall,
    output logic [PERF_W-1:0]       perf_bubble,
    output logic [PERF_W-1:0]       perf_flush
);

    if (STAGE_IDX + 1 >= STALL_W || STAGE_IDX < 0) begin : g_bad_stage
        $error("pipe_stage_reg: STAGE_IDX+1 must be < STALL_W");
    end
    if (LANES < 1 || LANES > LANES_MAX) begin : g_bad_lanes
        $error("pipe_stage_reg: LANES must be in 1..4");
    end
    if (DATA_W < 1) begin : g_bad_data
        $error("pipe_stage_reg: DATA_W must be at least 1");
    end

    logic up;
    logic dn;
    stage_ctl_e ctl;
    logic [LANES-1:0] live;
    logic [CNT_W-1:0] nxt_count;

    assign up = stall[STAGE_IDX];
    assign dn = stall[STAGE_IDX+1];
    assign ctl = decode_ctl(flush, up, dn);
    assign live = in_valid & ~in_kill;

    // Only the two owned stall bits matter; the rest of the bus is ignored.
    logic unused_stall;
    assign unused_stall = ^stall;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        pipe_lane_reg #(
            .PC_W(PC_W),
            .DATA_W(DATA_W)
        ) u_lane (
            .clk(clk),
            .resetn(resetn),
            .clr(ctl == CTL_CLEAR),
            .ld(ctl == CTL_LOAD),
            .nxt_valid(live[i]),
            .nxt_pc(in_pc[i*PC_W +: PC_W]),
            .nxt_data(in_data[i*DATA_W +: DATA_W]),
            .valid(out_valid[i]),
            .pc(out_pc[i*PC_W +: PC_W]),
            .data(out_data[i*DATA_W +: DATA_W])
        );
    end

    always_comb begin
        nxt_count = '0;
        for (int i = 0; i < LANES; i++) begin
            nxt_count = nxt_count + CNT_W'(live[i]);
        end
    end

    // Count tracks the value being loaded so it never lags out_valid.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            out_count <= '0;
        end else begin
            unique case (ctl)
                CTL_CLEAR: out_count <= '0;
                CTL_LOAD: out_count <= nxt_count;
                default: out_count <= out_count;
            endcase
        end
    end

`ifdef PIPE_STAGE_PERF_EN
    logic is_bubble;
    logic is_hold;
    logic [PERF_W-1:0] perf_stall_q;
    logic [PERF_W-1:0] perf_bubble_q;
    logic [PERF_W-1:0] perf_flush_q;

    assign is_bubble = !flush && up == STOP && dn == NO_STOP;
    assign is_hold = ctl == CTL_HOLD && |out_valid;

    always_ff @(posedge clk) begin
        if (!resetn || perf_clr) begin
            perf_stall_q <= '0;
            perf_bubble_q <= '0;
            perf_flush_q <= '0;
        end else begin
            if (is_hold) perf_stall_q <= sat_inc(perf_stall_q);
            if (is_bubble) perf_bubble_q <= sat_inc(perf_bubble_q);
            if (flush) perf_flush_q <= sat_inc(perf_flush_q);
        end
    end

    assign perf_stall = perf_stall_q;
    assign perf_bubble = perf_bubble_q;
    assign perf_flush = perf_flush_q;
`else
    logic unused_perf;
    assign unused_perf = perf_clr;
    assign perf_stall = '0;
    assign perf_bubble = '0;
    assign perf_flush = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: directed cases plus randomized traffic
// compared against a per-lane behavioural model every cycle.
module tb_pipe_stage_reg;

    localparam int LANES = 2;
    localparam int PC_W = 32;
    localparam int DATA_W = 64;
    localparam int STALL_W = 7;
    localparam int STAGE_IDX = 5;

    logic clk = 1'b0;
    logic resetn;
    logic flush;
    logic [STALL_W-1:0] stall;
    logic [LANES-1:0] in_valid;
    logic [LANES-1:0] in_kill;
    logic [LANES*PC_W-1:0] in_pc;
    logic [LANES*DATA_W-1:0] in_data;
    logic [LANES-1:0] out_valid;
    logic [LANES*PC_W-1:0] out_pc;
    logic [LANES*DATA_W-1:0] out_data;
    logic [1:0] out_count;
    logic perf_clr;
    logic [31:0] perf_stall;
    logic [31:0] perf_bubble;
    logic [31:0] perf_flush;

    always #5 clk = ~clk;

    pipe_stage_reg #(
        .LANES(LANES),
        .PC_W(PC_W),
        .DATA_W(DATA_W),
        .STALL_W(STALL_W),
        .STAGE_IDX(STAGE_IDX)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .flush(flush),
        .stall(stall),
        .in_valid(in_valid),
        .in_kill(in_kill),
        .in_pc(in_pc),
        .in_data(in_data),
        .out_valid(out_valid),
        .out_pc(out_pc),
        .out_data(out_data),
        .out_count(out_count),
        .perf_clr(perf_clr),
        .perf_stall(perf_stall),
        .perf_bubble(perf_bubble),
        .perf_flush(perf_flush)
    );

    int errors = 0;
    int checks = 0;

    bit m_valid [LANES];
    logic [PC_W-1:0] m_pc [LANES];
    logic [DATA_W-1:0] m_data [LANES];
    longint m_pstall, m_pbubble, m_pflush;

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic longint sat(input longint v);
        return (v >= 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : v + 1;
    endfunction

    task automatic model_update();
        bit up, dn, any;
        up = stall[STAGE_IDX];
        dn = stall[STAGE_IDX+1];
        any = 0;
        for (int i = 0; i < LANES; i++) any |= m_valid[i];
        if (!resetn) begin
            m_pstall = 0; m_pbubble = 0; m_pflush = 0;
        end else if (perf_clr) begin
            m_pstall = 0; m_pbubble = 0; m_pflush = 0;
        end else begin
            if (flush) m_pflush = sat(m_pflush);
            else if (up && !dn) m_pbubble = sat(m_pbubble);
            else if (up && dn && any) m_pstall = sat(m_pstall);
        end
        if (!resetn || flush || (up && !dn)) begin
            for (int i = 0; i < LANES; i++) begin
                m_valid[i] = 0; m_pc[i] = '0; m_data[i] = '0;
            end
        end else if (!up) begin
            for (int i = 0; i < LANES; i++) begin
                m_valid[i] = in_valid[i] && !in_kill[i];
                m_pc[i] = m_valid[i] ? in_pc[i*PC_W +: PC_W] : '0;
                m_data[i] = m_valid[i] ? in_data[i*DATA_W +: DATA_W] : '0;
            end
        end
    endtask

    task automatic compare_model();
        logic [LANES-1:0] ev;
        logic [LANES*PC_W-1:0] ep;
        logic [LANES*DATA_W-1:0] ed;
        int n;
        n = 0;
        for (int i = 0; i < LANES; i++) begin
            ev[i] = m_valid[i];
            ep[i*PC_W +: PC_W] = m_pc[i];
            ed[i*DATA_W +: DATA_W] = m_data[i];
            n += int'(m_valid[i]);
        end
        chk("out_valid", 128'(out_valid), 128'(ev));
        chk("out_pc", 128'(out_pc), 128'(ep));
        chk("out_data", 128'(out_data), 128'(ed));
        chk("out_count", 128'(out_count), 128'(n));
`ifdef PIPE_STAGE_PERF_EN
        chk("perf_stall", 128'(perf_stall), 128'(m_pstall));
        chk("perf_bubble", 128'(perf_bubble), 128'(m_pbubble));
        chk("perf_flush", 128'(perf_flush), 128'(m_pflush));
`else
        chk("perf_off", 128'({perf_stall, perf_bubble, perf_flush}), 128'(0));
`endif
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        @(negedge clk);
        compare_model();
    endtask

    initial begin
        resetn = 1'b0;
        flush = 1'b0;
        stall = '0;
        perf_clr = 1'b0;
        in_valid = 2'b11;
        in_kill = 2'b00;
        in_pc = {32'h8000_0004, 32'h8000_0000};
        in_data = {64'hAAAA_0001, 64'h5555_0000};
        m_pstall = 0; m_pbubble = 0; m_pflush = 0;
        @(negedge clk);
        step();
        step();
        chk("rst_valid", 128'(out_valid), 128'(0));
        chk("rst_pc", 128'(out_pc), 128'(0));
        chk("rst_count", 128'(out_count), 128'(0));

        resetn = 1'b1;
        step();
        chk("load_valid", 128'(out_valid), 128'(2'b11));
        chk("load_pc", 128'(out_pc), 128'({32'h8000_0004, 32'h8000_0000}));
        chk("load_count", 128'(out_count), 128'(2));

        stall = 7'b010_0000;
        step();
        chk("bubble_valid", 128'(out_valid), 128'(0));
        chk("bubble_pc", 128'(out_pc), 128'(0));
`ifdef PIPE_STAGE_PERF_EN
        chk("bubble_perf", 128'(perf_bubble), 128'(1));
`endif

        stall = '0;
        in_valid = 2'b01;
        in_pc = {32'h0000_0000, 32'hBFC0_0010};
        in_data = {64'h0, 64'h0000_1234};
        step();
        stall = 7'b110_0000;
        for (int k = 0; k < 3; k++) begin
            in_valid = 2'($urandom);
            in_pc = {$urandom, $urandom};
            step();
            chk("hold_pc", 128'(out_pc), 128'({32'h0, 32'hBFC0_0010}));
            chk("hold_valid", 128'(out_valid), 128'(2'b01));
        end
`ifdef PIPE_STAGE_PERF_EN
        chk("hold_perf", 128'(perf_stall), 128'(3));
`endif

        stall = '0;
        in_valid = 2'b11;
        in_kill = 2'b10;
        in_pc = {32'h1111_1110, 32'h2222_2220};
        in_data = {64'hDEAD_BEEF, 64'hCAFE_F00D};
        step();
        chk("kill_valid", 128'(out_valid), 128'(2'b01));
        chk("kill_pc", 128'(out_pc), 128'({32'h0, 32'h2222_2220}));
        chk("kill_data", 128'(out_data), 128'({64'h0, 64'hCAFE_F00D}));
        chk("kill_count", 128'(out_count), 128'(1));

        in_kill = 2'b00;
        in_valid = 2'b10;
        step();
        chk("lane1_only", 128'(out_valid), 128'(2'b10));

        stall = 7'b111_1111;
        flush = 1'b1;
        step();
        chk("flush_valid", 128'(out_valid), 128'(0));
        chk("flush_pc", 128'(out_pc), 128'(0));
`ifdef PIPE_STAGE_PERF_EN
        chk("flush_perf", 128'(perf_flush), 128'(1));
`endif
        flush = 1'b0;

        for (int k = 0; k < 3000; k++) begin
            resetn = ($urandom_range(0, 39) != 0);
            flush = ($urandom_range(0, 15) == 0);
            perf_clr = ($urandom_range(0, 63) == 0);
            stall = 7'($urandom);
            in_valid = 2'($urandom);
            in_kill = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
            in_pc = {$urandom, $urandom};
            in_data = {$urandom, $urandom, $urandom, $urandom};
            step();
        end

`ifdef PIPE_STAGE_PERF_EN
        resetn = 1'b1;
        flush = 1'b0;
        perf_clr = 1'b0;
        stall = '0;
        in_valid = 2'b01;
        in_kill = 2'b00;
        step();
        stall = 7'b110_0000;
        dut.perf_stall_q = 32'hFFFF_FFFE;
        m_pstall = 64'hFFFF_FFFE;
        step();
        chk("sat_reach", 128'(perf_stall), 128'(32'hFFFF_FFFF));
        step();
        chk("sat_hold", 128'(perf_stall), 128'(32'hFFFF_FFFF));
        perf_clr = 1'b1;
        step();
        chk("perf_clr", 128'(perf_stall), 128'(0));
        perf_clr = 1'b0;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
